rx_bg_top: RTL and testbench
============================

// Module: rx_bg_top
// PURPOSE
//  UART receiver with integrated 16x-oversampling baud-rate generator; receive-side counterpart of the TX+BG top.
//  Recovers 8N1 serial frames from i_rx, LSB first, and presents each byte with a 1-cycle done strobe.
//  Sits between the board RX pin and the UART FIFO/interface logic of the TP2 design.
// PARAMETERS
//  DBIT      8    data bits per frame
//  SB_TICK   16   oversampling ticks per stop bit (16 = 1 stop bit)
//  NB_STATE  2    width of the FSM state register
//  BAUD_DIV  163  i_clock cycles per oversampling tick (50 MHz / (19200*16), rounded)
//  NB_DIV    8    width of the baud divider counter (must satisfy 2^NB_DIV >= BAUD_DIV)
// PORTS
//  i_clock         in   1     system clock, 50 MHz
//  i_reset         in   1     asynchronous reset, active-high
//  i_rx            in   1     serial line, idle high, asynchronous to i_clock
//  o_data          out  DBIT  last received byte, held until the next frame completes
//  o_rx_done_tick  out  1     1-cycle strobe: o_data valid and updated
//  o_frame_err     out  1     only with RX_FRAMING_ERR_EN: stop bit sampled low
// BEHAVIOUR
//  Reset: i_reset=1 asynchronously forces state=IDLE, all counters=0, shift reg=0,
//   o_data=0, o_rx_done_tick=0, o_frame_err=0, sync FFs=1 (line idle).
//   Reset mid-frame aborts the frame; no done strobe is produced for it.
//  Baud gen: mod-BAUD_DIV counter; tick=1 for one cycle when count==BAUD_DIV-1, then wraps to 0. Free-running.
//  i_rx passes through a 2-FF synchronizer; the FSM sees only rx_sync. Previous value rx_prev kept for edge detect.
//  FSM (s = tick counter 0..15, n = bit counter 0..DBIT-1):
//   IDLE : rx_prev=1 && rx_sync=0 (falling edge) -> START, s=0. A line held low never re-triggers.
//   START: on tick; at s==7 (mid start bit): rx_sync==0 -> DATA, s=0, n=0;
//          rx_sync==1 -> IDLE (glitch rejected, no strobe). Else s++.
//   DATA : on tick; at s==15: shreg={rx_sync, shreg[DBIT-1:1]}, s=0;
//          n==DBIT-1 -> STOP, else n++. Else s++.
//   STOP : on tick; at s==SB_TICK-1: o_data<=shreg, o_rx_done_tick<=1 next cycle, -> IDLE. Else s++.
//  Sampling: every bit sampled at its centre (7 ticks after start-edge detect, then every 16 ticks).
//  Latency: done strobe is the i_clock cycle after the final stop-bit tick; ~9.5 bit periods after start edge.
//  o_rx_done_tick is registered, exactly 1 cycle wide, never asserted in consecutive cycles.
//  Back-to-back frames: falling edge in the cycle right after STOP->IDLE is accepted; no idle gap required.
//  Ticks not qualified by state are ignored; counters only advance on tick=1.
// CONFIGURATION
//  RX_FRAMING_ERR_EN defined: stop bit is sampled at s==7 in STOP; o_frame_err<=~rx_sync at that point, and
//   is driven with the done strobe and held until the next done strobe or reset. Data is still delivered.
//  Not defined: o_frame_err port absent; stop bit value ignored; behaviour otherwise identical.
// STRUCTURE
//  Shared header uart_defs.vh: state localparams IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11;
//   oversample constant OVERSAMPLE=16; mid-sample constant MID_TICK=7. Shared with the TX top.
//  Sub-module baud_rate_gen (BAUD_DIV, NB_DIV) -> o_tick; instantiated here, reused by TX side.
//  The synchronizer, FSM and shift register live in this module.
// TESTING  (20 ns clock; 1 bit = 16*163 = 2608 clocks = 52160 ns)
//  1. Send 0x55 (8N1) after reset -> one done strobe, o_data=0x55, o_frame_err=0.
//  2. Send 0xAA then 0x0F with zero idle gap -> two strobes, o_data 0xAA then 0x0F.
//  3. Drive i_rx low for 4 ticks (652 clocks) then high -> no strobe, FSM back in IDLE, o_data unchanged.
//  4. (RX_FRAMING_ERR_EN) Send 0xA5 with stop bit low, keep line low 20 bit times
//     -> one strobe, o_data=0xA5, o_frame_err=1; no further strobes while line stays low.
//  5. Assert i_reset during data bit 4 of 0x3C, release, resend 0x3C
//     -> outputs 0 during reset, no strobe for aborted frame, then o_data=0x3C.
//  6. Count clocks between consecutive baud ticks -> exactly 163, tick width 1 cycle.

Source files
------------

// File: rtl/rx_bg_top_pkg.sv
// rtl/rx_bg_top_pkg.sv - shared UART state encodings and oversampling constants (RX/TX)
package rx_bg_top_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'b00;
  localparam state_t START = 2'b01;
  localparam state_t DATA  = 2'b10;
  localparam state_t STOP  = 2'b11;

  // Ticks per bit and the tick index of the bit centre
  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = 7;

endpackage

// File: rtl/rx_bg_top_baud_rate_gen.sv
// rtl/rx_bg_top_baud_rate_gen.sv - free-running mod-BAUD_DIV counter producing the 16x oversampling tick
module baud_rate_gen #(
  parameter int BAUD_DIV = 163,
  parameter int NB_DIV   = 8
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_tick
);

  logic [NB_DIV-1:0] cnt;

  assign o_tick = (cnt == NB_DIV'(BAUD_DIV - 1));

  // Count 0..BAUD_DIV-1 and wrap; the tick marks the last count
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)
      cnt <= '0;
    else if (o_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/rx_bg_top.sv
// rtl/rx_bg_top.sv - 8N1 UART receiver with built-in baud generator; optional RX_FRAMING_ERR_EN stop-bit check
module rx_bg_top #(
  parameter int DBIT     = 8,
  parameter int SB_TICK  = 16,
  parameter int NB_STATE = 2,
  parameter int BAUD_DIV = 163,
  parameter int NB_DIV   = 8
) (
  input  logic            i_clock,
  input  logic            i_reset,
  input  logic            i_rx,
  output logic [DBIT-1:0] o_data,
  output logic            o_rx_done_tick
`ifdef RX_FRAMING_ERR_EN
  ,
  output logic            o_frame_err
`endif
);

  import rx_bg_top_pkg::*;

  localparam int NB_S = $clog2((SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE);
  localparam int NB_N = (DBIT > 1) ? $clog2(DBIT) : 1;

  logic                tick;
  logic                rx_meta;
  logic                rx_sync;
  logic                rx_prev;
  logic [NB_STATE-1:0] state;
  logic [NB_S-1:0]     s_cnt;
  logic [NB_N-1:0]     n_cnt;
  logic [DBIT-1:0]     shreg;
`ifdef RX_FRAMING_ERR_EN
  logic                stop_bad;
`endif

  baud_rate_gen #(
    .BAUD_DIV (BAUD_DIV),
    .NB_DIV   (NB_DIV)
  ) u_baud (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .o_tick  (tick)
  );

  // Two-flop synchronizer plus one delayed copy for falling-edge detection; idles high
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  // Frame FSM: edge-triggered start, mid-bit sampling, byte hand-off with a one-cycle strobe
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state          <= IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      shreg          <= '0;
      o_data         <= '0;
      o_rx_done_tick <= 1'b0;
`ifdef RX_FRAMING_ERR_EN
      stop_bad       <= 1'b0;
      o_frame_err    <= 1'b0;
`endif
    end else begin
      o_rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Needs a real 1->0 transition, so a line stuck low never restarts a frame
          if (rx_prev && !rx_sync) begin
            state <= START;
            s_cnt <= '0;
          end
        end
        START: begin
          if (tick) begin
            if (s_cnt == NB_S'(MID_TICK)) begin
              if (!rx_sync) begin
                state <= DATA;
                s_cnt <= '0;
                n_cnt <= '0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        DATA: begin
          if (tick) begin
            if (s_cnt == NB_S'(OVERSAMPLE - 1)) begin
              shreg <= {rx_sync, shreg[DBIT-1:1]};
              s_cnt <= '0;
              if (n_cnt == NB_N'(DBIT - 1))
                state <= STOP;
              else
                n_cnt <= n_cnt + 1'b1;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        STOP: begin
          if (tick) begin
`ifdef RX_FRAMING_ERR_EN
            if (s_cnt == NB_S'(MID_TICK))
              stop_bad <= ~rx_sync;
`endif
            if (s_cnt == NB_S'(SB_TICK - 1)) begin
              o_data         <= shreg;
              o_rx_done_tick <= 1'b1;
`ifdef RX_FRAMING_ERR_EN
              o_frame_err    <= stop_bad;
`endif
              state          <= IDLE;
            end else begin
              s_cnt <= s_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_bg_top.sv
// tb/tb_rx_bg_top.sv - scoreboard bench for rx_bg_top; honours RX_FRAMING_ERR_EN
`timescale 1ns/1ps
module tb_rx_bg_top;

  import rx_bg_top_pkg::*;

  localparam int BAUD_DIV = 5;
  localparam int NB_DIV   = 3;
  localparam int BIT_CLKS = 16 * BAUD_DIV;

  logic       i_clock = 1'b0;
  logic       i_reset;
  logic       i_rx;
  logic [7:0] o_data;
  logic       o_rx_done_tick;
  logic       frame_err_obs;
`ifdef RX_FRAMING_ERR_EN
  logic       o_frame_err;
  assign frame_err_obs = o_frame_err;
`else
  assign frame_err_obs = 1'b0;
`endif

  int         n_cmp = 0;
  int         n_fail = 0;
  logic [8:0] exp_q[$];
  logic [8:0] got_q[$];
  int         consec_cnt = 0;
  logic       prev_done = 1'b0;

  always #10 i_clock = ~i_clock;

  rx_bg_top #(
    .DBIT     (8),
    .SB_TICK  (16),
    .NB_STATE (2),
    .BAUD_DIV (BAUD_DIV),
    .NB_DIV   (NB_DIV)
  ) dut (
    .i_clock        (i_clock),
    .i_reset        (i_reset),
    .i_rx           (i_rx),
    .o_data         (o_data),
    .o_rx_done_tick (o_rx_done_tick)
`ifdef RX_FRAMING_ERR_EN
    ,
    .o_frame_err    (o_frame_err)
`endif
  );

  // Capture every delivered byte on the falling edge, away from the active edge
  always @(negedge i_clock) begin
    if (o_rx_done_tick === 1'b1)
      got_q.push_back({frame_err_obs, o_data});
    if (o_rx_done_tick === 1'b1 && prev_done === 1'b1)
      consec_cnt++;
    prev_done = o_rx_done_tick;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge i_clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    i_rx = 1'b0;
    clks(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      i_rx = b[i];
      clks(BIT_CLKS);
    end
    i_rx = stop_bit;
    clks(BIT_CLKS);
  endtask

  task automatic expect_frame(input logic [7:0] b, input logic err);
    exp_q.push_back({err, b});
  endtask

  task automatic drain(input string tag);
    int n;
    logic [8:0] e;
    logic [8:0] g;
    check({tag, "_strobes"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      check({tag, "_byte"}, {23'd0, g}, {23'd0, e});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int k;
    i_reset = 1'b1;
    i_rx    = 1'b1;
    clks(3);
    check("reset_data", o_data, 8'h00);
    check("reset_done", o_rx_done_tick, 1'b0);
    check("reset_state", dut.state, IDLE);
    check("reset_ferr", frame_err_obs, 1'b0);
    i_reset = 1'b0;
    clks(2 * BIT_CLKS);

    // Baud tick period and width
    @(negedge i_clock);
    k = 0;
    while (dut.tick !== 1'b1 && k < 50) begin
      @(negedge i_clock);
      k++;
    end
    check("tick_seen", (k < 50), 1'b1);
    @(negedge i_clock);
    check("tick_width", dut.tick, 1'b0);
    k = 1;
    while (dut.tick !== 1'b1 && k < 50) begin
      @(negedge i_clock);
      k++;
    end
    check("tick_period", k, BAUD_DIV);
    clks(1);

    // Single frame
    expect_frame(8'h55, 1'b0);
    send_byte(8'h55, 1'b1);
    clks(4);
    drain("f55");
    clks(BIT_CLKS);

    // Back-to-back frames, no idle gap
    expect_frame(8'hAA, 1'b0);
    expect_frame(8'h0F, 1'b0);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h0F, 1'b1);
    clks(4);
    drain("b2b");
    clks(BIT_CLKS);

    // Short low glitch is rejected at the start-bit centre
    i_rx = 1'b0;
    clks(4 * BAUD_DIV);
    i_rx = 1'b1;
    clks(2 * BIT_CLKS);
    check("glitch_state", dut.state, IDLE);
    check("glitch_data", o_data, 8'h0F);
    drain("glitch");

    // Low stop bit, then line stuck low for 20 bit times
`ifdef RX_FRAMING_ERR_EN
    expect_frame(8'hA5, 1'b1);
`else
    expect_frame(8'hA5, 1'b0);
`endif
    send_byte(8'hA5, 1'b0);
    clks(20 * BIT_CLKS);
    drain("stuck_low");
    check("stuck_low_state", dut.state, IDLE);
    i_rx = 1'b1;
    clks(2 * BIT_CLKS);

    // Reset in the middle of data bit 4 of 0x3C
    i_rx = 1'b0;
    clks(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      i_rx = 8'h3C >> i;
      clks(BIT_CLKS);
    end
    i_rx = 1'b1;
    clks(BIT_CLKS / 2);
    check("pre_reset_state", dut.state, DATA);
    i_reset = 1'b1;
    #2;
    check("midreset_data", o_data, 8'h00);
    check("midreset_done", o_rx_done_tick, 1'b0);
    check("midreset_state", dut.state, IDLE);
    check("midreset_ferr", frame_err_obs, 1'b0);
    clks(5);
    i_reset = 1'b0;
    clks(2 * BIT_CLKS);
    drain("aborted");
    expect_frame(8'h3C, 1'b0);
    send_byte(8'h3C, 1'b1);
    clks(4);
    drain("f3C");

    check("no_consecutive_strobes", consec_cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
